// File: rtl/prod_accum_if.sv
// Handshake bundle for the product accumulator: product input stream and group result output.
// Master drives products and result acceptance; slave is the accumulator.
interface prod_accum_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
);
  logic [7:0]       prod;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output prod, in_valid, in_last, out_ready,
    input  in_ready, sum, count, ovf, out_valid
  );

  modport slave (
    input  prod, in_valid, in_last, out_ready,
    output in_ready, sum, count, ovf, out_valid
  );
endinterface

// File: rtl/prod_accum.sv
// Sums groups of 8-bit multiplier products; a group closes on in_last or at MAX_TERMS terms.
// Latency: result registered 1 cycle after the closing beat is accepted.
// Backpressure: in_ready drops while a result is held; it returns after the out_valid/out_ready handshake.
module prod_accum #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input logic         clk,
  input logic         rst,
  prod_accum_if.slave io
);

  if (ACC_W < 8) begin : g_bad_acc_w
    $error("prod_accum: ACC_W must be >= 8");
  end
  if (MAX_TERMS < 1 || MAX_TERMS > (1 << CNT_W) - 1) begin : g_bad_terms
    $error("prod_accum: MAX_TERMS must be >= 1 and fit in CNT_W bits");
  end

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  res_t             res;
  logic             out_valid_r;

  logic [ACC_W:0]   acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             close_grp;

  // Bit ACC_W of acc_nxt is the carry out of the accumulator for this beat.
  assign acc_nxt   = {1'b0, acc} + (ACC_W+1)'(io.prod);
  assign cnt_nxt   = cnt + CNT_W'(1);
  assign accept    = io.in_valid && (state == ACC);
  assign close_grp = io.in_last || (cnt_nxt == CNT_W'(MAX_TERMS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      ovf_r       <= 1'b0;
      res         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (close_grp) begin
              res.sum     <= acc_nxt[ACC_W-1:0];
              res.count   <= cnt_nxt;
              res.ovf     <= ovf_r | acc_nxt[ACC_W];
              out_valid_r <= 1'b1;
              state       <= DONE;
              acc         <= '0;
              cnt         <= '0;
              ovf_r       <= 1'b0;
            end else begin
              acc   <= acc_nxt[ACC_W-1:0];
              cnt   <= cnt_nxt;
              ovf_r <= ovf_r | acc_nxt[ACC_W];
            end
          end
        end
        DONE: begin
          if (out_valid_r && io.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ACC;
          end
        end
      endcase
    end
  end

  assign io.in_ready  = (state == ACC);
  assign io.sum       = res.sum;
  assign io.count     = res.count;
  assign io.ovf       = res.ovf;
  assign io.out_valid = out_valid_r;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three instances (default, ACC_W=10, MAX_TERMS=1) driven from a vector table
// plus hand sequences for reset, backpressure and limit handling; results checked against a queue.
module tb_prod_accum;

  logic clk;
  logic rst;

  logic [7:0]  prod_d [3];
  logic        vld_d  [3];
  logic        last_d [3];
  logic        ordy_d [3];
  logic [11:0] sum_o  [3];
  logic [4:0]  cnt_o  [3];
  logic        ovf_o  [3];
  logic        ovld_o [3];
  logic        irdy_o [3];

  prod_accum_if #(.ACC_W(12), .CNT_W(5)) if_a ();
  prod_accum_if #(.ACC_W(10), .CNT_W(5)) if_b ();
  prod_accum_if #(.ACC_W(12), .CNT_W(5)) if_c ();

  prod_accum #(.ACC_W(12), .MAX_TERMS(16), .CNT_W(5)) u_a (.clk(clk), .rst(rst), .io(if_a));
  prod_accum #(.ACC_W(10), .MAX_TERMS(16), .CNT_W(5)) u_b (.clk(clk), .rst(rst), .io(if_b));
  prod_accum #(.ACC_W(12), .MAX_TERMS(1),  .CNT_W(5)) u_c (.clk(clk), .rst(rst), .io(if_c));

  assign if_a.prod = prod_d[0];  assign if_a.in_valid = vld_d[0];
  assign if_a.in_last = last_d[0]; assign if_a.out_ready = ordy_d[0];
  assign if_b.prod = prod_d[1];  assign if_b.in_valid = vld_d[1];
  assign if_b.in_last = last_d[1]; assign if_b.out_ready = ordy_d[1];
  assign if_c.prod = prod_d[2];  assign if_c.in_valid = vld_d[2];
  assign if_c.in_last = last_d[2]; assign if_c.out_ready = ordy_d[2];

  assign sum_o[0] = if_a.sum;        assign cnt_o[0] = if_a.count;
  assign sum_o[1] = 12'(if_b.sum);   assign cnt_o[1] = if_b.count;
  assign sum_o[2] = if_c.sum;        assign cnt_o[2] = if_c.count;
  assign ovf_o[0] = if_a.ovf;        assign ovld_o[0] = if_a.out_valid; assign irdy_o[0] = if_a.in_ready;
  assign ovf_o[1] = if_b.ovf;        assign ovld_o[1] = if_b.out_valid; assign irdy_o[1] = if_b.in_ready;
  assign ovf_o[2] = if_c.ovf;        assign ovld_o[2] = if_c.out_valid; assign irdy_o[2] = if_c.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [11:0] s;
    logic [4:0]  c;
    logic        o;
  } res_t;

  typedef struct {
    int             dut;
    int             n;
    logic [3:0][7:0] pv;
    bit             use_last;
    bit             gaps;
    logic [11:0]    s;
    logic [4:0]     c;
    logic           o;
  } vec_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic res_t mk_res(int dut, int s, int c, int o);
    res_t r;
    r.dut = dut; r.s = 12'(s); r.c = 5'(c); r.o = 1'(o);
    return r;
  endfunction

  function automatic vec_t mk(int dut, int n, int p0, int p1, int p2, int p3,
                              bit use_last, bit gaps, int s, int c, int o);
    vec_t v;
    v.dut = dut; v.n = n;
    v.pv[0] = 8'(p0); v.pv[1] = 8'(p1); v.pv[2] = 8'(p2); v.pv[3] = 8'(p3);
    v.use_last = use_last; v.gaps = gaps;
    v.s = 12'(s); v.c = 5'(c); v.o = 1'(o);
    return v;
  endfunction

  // Results are checked on the cycle the handshake is about to complete.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && ovld_o[k] && ordy_d[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("result dut", k, e.dut);
          chk("result sum", int'(sum_o[k]), int'(e.s));
          chk("result count", int'(cnt_o[k]), int'(e.c));
          chk("result ovf", int'(ovf_o[k]), int'(e.o));
        end
      end
    end
  end

  // Callers sit 1 time unit after a rising edge; returns likewise, after the beat was taken.
  task automatic send_beat(input int k, input logic [7:0] p, input logic lst);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    prod_d[k] = p; vld_d[k] = 1'b1; last_d[k] = lst;
    while (!done) begin
      @(negedge clk);
      if (irdy_o[k]) begin
        done = 1'b1;
      end else if (waited >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, expected 1", waited);
        done = 1'b1;
      end
      waited++;
      @(posedge clk); #1;
    end
    vld_d[k] = 1'b0; last_d[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(0, 3,   6, 225,   0,   0, 1, 0,  231,  3, 0);
    tbl[1]  = mk(0, 3,   6, 225,   0,   0, 1, 1,  231,  3, 0);
    tbl[2]  = mk(0, 16, 225, 225, 225, 225, 0, 0, 3600, 16, 0);
    tbl[3]  = mk(0, 16, 255, 255, 255, 255, 0, 0, 4080, 16, 0);
    tbl[4]  = mk(0, 1, 200,   0,   0,   0, 1, 0,  200,  1, 0);
    tbl[5]  = mk(0, 4,   1,   2,   3,   4, 1, 1,   10,  4, 0);
    tbl[6]  = mk(1, 5, 225, 225, 225, 225, 1, 0,  101,  5, 1);
    tbl[7]  = mk(1, 2,   1,   1,   1,   1, 1, 0,    2,  2, 0);
    tbl[8]  = mk(1, 16, 255, 255, 255, 255, 0, 0, 1008, 16, 1);
    tbl[9]  = mk(2, 1,  77,   0,   0,   0, 1, 0,   77,  1, 0);
    tbl[10] = mk(2, 1, 255,   0,   0,   0, 0, 0,  255,  1, 0);
    tbl[11] = mk(2, 1,   0,   0,   0,   0, 1, 1,    0,  1, 0);
    tbl[12] = mk(0, 8, 128, 128, 128, 128, 1, 0, 1024,  8, 0);

    for (int k = 0; k < 3; k++) begin
      prod_d[k] = 8'd0; vld_d[k] = 1'b0; last_d[k] = 1'b0; ordy_d[k] = 1'b1;
    end
    prod_d[0] = 8'd55; vld_d[0] = 1'b1;
    rst = 1'b1;

    // Reset state, with a valid beat presented during reset.
    #8;
    for (int k = 0; k < 3; k++) begin
      chk("reset out_valid", int'(ovld_o[k]), 0);
      chk("reset sum", int'(sum_o[k]), 0);
      chk("reset count", int'(cnt_o[k]), 0);
      chk("reset ovf", int'(ovf_o[k]), 0);
    end
    vld_d[0] = 1'b0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", int'(irdy_o[0]), 1);
    chk("no result after reset", int'(ovld_o[0]), 0);

    for (int r = 0; r < 13; r++) begin
      int k;
      k = tbl[r].dut;
      exp_q.push_back(mk_res(k, int'(tbl[r].s), int'(tbl[r].c), int'(tbl[r].o)));
      for (int i = 0; i < tbl[r].n; i++) begin
        send_beat(k, tbl[r].pv[(i > 3) ? 3 : i], tbl[r].use_last && (i == tbl[r].n - 1));
        if (tbl[r].gaps && i < tbl[r].n - 1) idle(2);
      end
      chk("latency out_valid", int'(ovld_o[k]), 1);
      idle(1);
      chk("post handshake out_valid", int'(ovld_o[k]), 0);
      chk("post handshake in_ready", int'(irdy_o[k]), 1);
      chk("queue drained", exp_q.size(), 0);
    end

    // Forced close at the limit while the consumer stalls; the next beat waits for the handshake.
    ordy_d[0] = 1'b0;
    exp_q.push_back(mk_res(0, 3600, 16, 0));
    for (int i = 0; i < 16; i++) send_beat(0, 8'd225, 1'b0);
    prod_d[0] = 8'd9; vld_d[0] = 1'b1; last_d[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp in_ready", int'(irdy_o[0]), 0);
      chk("bp sum", int'(sum_o[0]), 3600);
      chk("bp count", int'(cnt_o[0]), 16);
      @(posedge clk); #1;
    end
    ordy_d[0] = 1'b1;
    exp_q.push_back(mk_res(0, 9, 1, 0));
    send_beat(0, 8'd9, 1'b1);
    chk("bp next group valid", int'(ovld_o[0]), 1);
    idle(1);
    chk("bp queue drained", exp_q.size(), 0);

    // Reset mid-group discards the partial sum.
    send_beat(0, 8'd100, 1'b0);
    send_beat(0, 8'd100, 1'b0);
    prod_d[0] = 8'd50; vld_d[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midgroup rst out_valid", int'(ovld_o[0]), 0);
    chk("midgroup rst sum", int'(sum_o[0]), 0);
    chk("midgroup rst count", int'(cnt_o[0]), 0);
    chk("midgroup rst ovf", int'(ovf_o[0]), 0);
    vld_d[0] = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("midgroup rst in_ready", int'(irdy_o[0]), 1);
    exp_q.push_back(mk_res(0, 5, 1, 0));
    send_beat(0, 8'd5, 1'b1);
    idle(1);
    chk("midgroup queue drained", exp_q.size(), 0);

    // Reset while a result is held drops it immediately.
    ordy_d[0] = 1'b0;
    send_beat(0, 8'd40, 1'b1);
    chk("done held valid", int'(ovld_o[0]), 1);
    chk("done held sum", int'(sum_o[0]), 40);
    #2 rst = 1'b1;
    #1;
    chk("done rst out_valid", int'(ovld_o[0]), 0);
    chk("done rst sum", int'(sum_o[0]), 0);
    @(negedge clk); #2 rst = 1'b0;
    ordy_d[0] = 1'b1;
    @(posedge clk); #1;
    chk("done rst in_ready", int'(irdy_o[0]), 1);

    // Single-term groups presented back to back.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_res(2, 10 * (i + 1), 1, 0));
      send_beat(2, 8'(10 * (i + 1)), 1'b0);
    end
    idle(2);
    chk("max1 queue drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Sequential accumulation stage directly downstream of the 4-bit array multiplier (x[3:0]*y[3:0] -> o[7:0]).
- Consumes one 8-bit product per accepted beat and sums a group of products terminated by a last flag or a term limit.
- Presents the group sum, term count and overflow flag on a valid/ready output.
- Forms the accumulate half of the team's multiply-accumulate path; the multiplier itself stays purely combinational.

Parameters:
- ACC_W, 12, accumulator/sum width in bits; must be >= 8.
- MAX_TERMS, 16, maximum products per group; the group closes automatically at this count; must be >= 1.
- CNT_W, 5, width of term counter; must hold MAX_TERMS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- prod  input  8  product from multiplier output o[7:0], unsigned.
- in_valid  input  1  prod is valid this cycle.
- in_last  input  1  qualifies prod as final term of group; sampled only on accept.
- in_ready  output  1  stage can accept a product.
- sum  output  ACC_W  group sum, modulo 2^ACC_W.
- count  output  CNT_W  number of terms in the group.
- ovf  output  1  carry out of ACC_W occurred during the group.
- out_valid  output  1  sum/count/ovf are valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: while rst is high, all state clears immediately (async): state=ACC, acc=0, cnt=0, ovf_r=0, sum=0, count=0, ovf=0, out_valid=0. in_ready is 1 from the first cycle after reset deassertion.
- States:
  - ACC: collecting terms.
  - DONE: holding the result.
- in_ready = (state==ACC). It is a combinational decode of the state register only; there is no path from out_ready.
- Accept in ACC: on in_valid & in_ready:
  - {carry, acc} <= acc + zero_extend(prod).
  - ovf_r <= ovf_r | carry.
  - cnt <= cnt+1.
- Group close: on an accepted beat, the group closes if in_last==1 or cnt+1==MAX_TERMS. At the next edge:
  - sum <= acc+prod, truncated to ACC_W.
  - count <= cnt+1.
  - ovf <= ovf_r | carry.
  - out_valid <= 1, state <= DONE.
  - acc, cnt and ovf_r clear to 0.
- Latency: result is visible 1 cycle after the closing beat is accepted.
- Throughput: max one beat per cycle in ACC. One group costs N accept cycles plus at least 1 DONE cycle.
- In DONE:
  - in_ready=0; prod, in_valid and in_last are ignored.
  - sum, count, ovf and out_valid hold stable until out_valid & out_ready.
  - On that handshake, at the next edge: out_valid <= 0, state <= ACC. sum, count and ovf keep their last values; they are don't-care while out_valid=0.
- out_ready while out_valid=0: no effect.
- in_valid=0 in ACC: no change.
- Partial groups persist indefinitely; there is no timeout.
- Wrap-around: the sum wraps modulo 2^ACC_W, and ovf is sticky for the group only. The term counter never exceeds MAX_TERMS, because the forced close fires at MAX_TERMS.
- MAX_TERMS=1: every accepted beat closes a group.
- Reset mid-operation:
  - Mid-group: the partial accumulation is discarded.
  - During DONE: the pending result is dropped, out_valid falls immediately.
- Must not be a combinational pass-through: prod never reaches sum without a register.

Test Plan:
- Reset: assert rst mid-cycle with in_valid=1 -> out_valid=0, sum=0, count=0, ovf=0 immediately; in_ready=1 the cycle after release.
- Basic group: prods 6 (2*3), 225 (15*15), 0 (last) over consecutive cycles, out_ready=1 -> one cycle after last accept: out_valid=1, sum=231, count=3, ovf=0; next cycle out_valid=0, in_ready=1.
- Auto close at limit: 16 beats of prod=225, in_last never set -> sum=3600, count=16, ovf=0; a 17th beat presented is held off (in_ready=0) until the result handshake, then accepted as term 1 of a new group.
- Backpressure: close a group with out_ready=0 for 5 cycles while in_valid=1 with prod=9 -> sum/count stable, in_ready=0 and no beats absorbed; raise out_ready -> handshake completes, then prod=9 is accepted.
- Overflow (ACC_W=10): five beats of 225, last on fifth -> sum=101 (1125 mod 1024), count=5, ovf=1; next group 1+1 last -> sum=2, ovf=0.
- Gaps and MAX_TERMS=1: in_valid toggled with idle cycles gives the same sum as back-to-back; with MAX_TERMS=1, each beat prod=p gives sum=p, count=1.
